// File: rtl/i_cache_pkg.sv
// i_cache_pkg: shared FSM states, counter width and address-field width helpers
package i_cache_pkg;
  typedef enum logic [1:0] {IDLE, MISS, REFILL, FLUSH} state_t;
  localparam int CNT_W = 16;
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words);
  endfunction
endpackage

// File: rtl/i_cache_way.sv
// i_cache_way: one way's valid bits plus tag and line storage, with a per-set clear port
module i_cache_way #(
  parameter int SETS = 64,
  parameter int TAG_W = 22,
  parameter int LINE_W = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(SETS)-1:0] rd_idx,
  output logic                    rd_vld,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [LINE_W-1:0]       rd_line,
  input  logic                    we,
  input  logic [$clog2(SETS)-1:0] wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [LINE_W-1:0]       wr_line,
  input  logic                    clr,
  input  logic [$clog2(SETS)-1:0] clr_idx
);
  logic [SETS-1:0]   vld;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];
  assign rd_vld  = vld[rd_idx];
  assign rd_tag  = tags[rd_idx];
  assign rd_line = lines[rd_idx];
  always_ff @(posedge clk)
    if (!rst_n) vld <= '0;
    else begin
      if (clr) vld[clr_idx] <= 1'b0;
      if (we) vld[wr_idx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_line;
    end
endmodule

// File: rtl/i_cache_assoc.sv
// i_cache_assoc: 1/2-way set-associative instruction cache with LRU, line refill and full flush
module i_cache_assoc
  import i_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall_n,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                    flush,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WS_W  = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  line_t             line_buf;
  logic [SETS-1:0]   lru;
  logic              pend;
  logic [IDX_W-1:0]  flush_idx, cpu_idx, lat_idx, rd_idx;
  logic [TAG_W-1:0]  cpu_tag, lat_tag;
  logic [WS_W-1:0]   cpu_ws, lat_ws;
  logic [WAYS-1:0]   way_vld, hv, vict;
  logic [TAG_W-1:0]  way_tag [WAYS];
  line_t             way_line [WAYS];
  logic              hit, go_flush;
  logic [31:0]       hit_word;
  assign cpu_idx = IDX_W'(cpu_addr >> OFF_W);
  assign lat_idx = IDX_W'(lat_addr >> OFF_W);
  assign cpu_tag = TAG_W'(cpu_addr >> (OFF_W + IDX_W));
  assign lat_tag = TAG_W'(lat_addr >> (OFF_W + IDX_W));
  assign cpu_ws  = LINE_WORDS > 1 ? WS_W'(cpu_addr >> 2) : '0;
  assign lat_ws  = LINE_WORDS > 1 ? WS_W'(lat_addr >> 2) : '0;
  // The single read port looks up the CPU address in IDLE and the latched miss set otherwise
  assign rd_idx   = state == IDLE ? cpu_idx : lat_idx;
  assign hit      = |hv;
  assign go_flush = flush || pend;
  assign cpu_stall_n = state == IDLE && !(cpu_req && (go_flush || !hit));
  always_comb begin
    hv       = '0;
    vict     = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hv[w]     = way_vld[w] && way_tag[w] == cpu_tag;
      hit_word |= hv[w] ? way_line[w][cpu_ws] : '0;
      vict[w]   = w == 0 ? (WAYS == 1 || !way_vld[0] || (way_vld[WAYS-1] && !lru[lat_idx]))
                         : (way_vld[0] && (!way_vld[w] || lru[lat_idx]));
    end
  end
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    i_cache_way #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(32*LINE_WORDS)) u_way (
      .clk(clk),
      .rst_n(rst_n),
      .rd_idx(rd_idx),
      .rd_vld(way_vld[w]),
      .rd_tag(way_tag[w]),
      .rd_line(way_line[w]),
      .we(state == REFILL && vict[w]),
      .wr_idx(lat_idx),
      .wr_tag(lat_tag),
      .wr_line(line_buf),
      .clr(state == FLUSH),
      .clr_idx(flush_idx)
    );
  end
  // lru holds the least-recently-used way of each set
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      lru       <= '0;
      pend      <= 1'b0;
      flush_idx <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else
      case (state)
        IDLE:
          if (go_flush) begin
            state     <= FLUSH;
            pend      <= 1'b0;
            flush_idx <= '0;
          end else if (cpu_req && hit) begin
            cpu_rdata    <= hit_word;
            lru[cpu_idx] <= hv[0];
            hit_cnt      <= hit_cnt + CNT_W'(hit_cnt != '1);
          end else if (cpu_req) begin
            state    <= MISS;
            lat_addr <= cpu_addr;
            mem_req  <= 1'b1;
            mem_addr <= (cpu_addr >> OFF_W) << OFF_W;
            miss_cnt <= miss_cnt + CNT_W'(miss_cnt != '1);
          end
        MISS: begin
          pend <= pend || flush;
          if (mem_ack) begin
            state    <= REFILL;
            line_buf <= mem_rdata;
            mem_req  <= 1'b0;
          end
        end
        REFILL: begin
          state        <= IDLE;
          pend         <= pend || flush;
          cpu_rdata    <= line_buf[lat_ws];
          lru[lat_idx] <= vict[0];
        end
        default: begin
          flush_idx <= flush_idx + 1'b1;
          if (flush_idx == IDX_W'(SETS - 1)) state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_i_cache_assoc.sv
// tb_i_cache_assoc: randomized fetch traffic checked against a recency-list cache model
module tb_i_cache_assoc;
  logic         clk = 1'b0, rst_n = 1'b0, cpu_req = 1'b0, mem_ack = 1'b0, flush = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [127:0] mem_rdata = '0;
  logic [31:0]  cpu_rdata, mem_addr;
  logic         cpu_stall_n, mem_req;
  logic [15:0]  hit_cnt, miss_cnt;
  int           n_cmp = 0, n_bad = 0;
  logic [21:0]  mq [64][$];
  int           m_hits = 0, m_miss = 0;

  i_cache_assoc dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_stall_n(cpu_stall_n), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a[31:4] == 28'h4 ? 32'hD0 + 32'(a[3:2]) : {a[31:2], 2'b00} ^ 32'h9E37_79B1;
  endfunction

  function automatic void mdl_clear();
    for (int s = 0; s < 64; s++) mq[s].delete();
  endfunction

  // Each set is a list of resident tags, most recent first, at most two long
  function automatic bit mdl_access(input logic [31:0] a);
    int s;
    logic [21:0] t;
    s = int'(a[9:4]);
    t = a[31:10];
    for (int i = 0; i < mq[s].size(); i++)
      if (mq[s][i] == t) begin
        mq[s].delete(i);
        mq[s].push_front(t);
        if (m_hits < 65535) m_hits++;
        return 1'b1;
      end
    if (mq[s].size() == 2) void'(mq[s].pop_back());
    mq[s].push_front(t);
    if (m_miss < 65535) m_miss++;
    return 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge after the word has been delivered
  task automatic fetch(input logic [31:0] a, input int flush_at, output logic hit,
                       output logic [31:0] word, output logic [31:0] maddr,
                       output logic stable, output logic ok);
    int mc;
    logic acked;
    mc = 0; acked = 1'b0; ok = 1'b0; hit = 1'b0; maddr = '0; stable = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = a;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (acked) begin
        cpu_req = 1'b0; mem_ack = 1'b0; flush = 1'b0;
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      if (cpu_stall_n) begin
        hit = n == 0;
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      flush = mem_req && mc == flush_at;
      if (mem_req) begin
        if (mc > 0 && mem_addr !== maddr) stable = 1'b0;
        maddr = mem_addr;
        mc++;
        if (mc > 3) begin
          mem_ack = 1'b1;
          mem_rdata = {mem_word(maddr + 12), mem_word(maddr + 8), mem_word(maddr + 4), mem_word(maddr)};
          acked = 1'b1;
        end
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    flush = 1'b0;
    word = cpu_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    @(negedge clk);
    n_cmp++;
    if ({cpu_rdata, mem_req, mem_addr, hit_cnt, miss_cnt, cpu_stall_n} !== {32'h0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", {cpu_rdata, mem_req, mem_addr, hit_cnt, miss_cnt, cpu_stall_n},
               {32'h0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1});
    end
  endtask

  task automatic test_cold_miss();
    logic h, st, ok;
    logic [31:0] w, ma;
    fetch(32'h40, -1, h, w, ma, st, ok);
    void'(mdl_access(32'h40));
    n_cmp++;
    if ({ok, h, st, ma} !== {3'b101, 32'h40}) begin
      n_bad++; $display("FAIL cold_miss_req: got ok/hit/stable/addr %b%b%b %h want 101 00000040", ok, h, st, ma);
    end
    n_cmp++;
    if (w !== 32'hD0) begin n_bad++; $display("FAIL cold_miss_rdata: got %h want 000000d0", w); end
    n_cmp++;
    if (miss_cnt !== 16'd1) begin n_bad++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    fetch(32'h44, -1, h, w, ma, st, ok);
    void'(mdl_access(32'h44));
    n_cmp++;
    if ({ok, h} !== 2'b11) begin n_bad++; $display("FAIL cold_hit_flag: got ok/hit %b%b want 11", ok, h); end
    n_cmp++;
    if (w !== 32'hD1) begin n_bad++; $display("FAIL cold_hit_rdata: got %h want 000000d1", w); end
    n_cmp++;
    if (hit_cnt !== 16'd1) begin n_bad++; $display("FAIL cold_hit_cnt: got %0d want 1", hit_cnt); end
  endtask

  task automatic test_conflict_lru();
    logic [31:0] seq [6] = '{32'h040, 32'h440, 32'h040, 32'h840, 32'h040, 32'h440};
    logic exp_hit [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic h, st, ok, mh;
    logic [31:0] w, ma;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      mh = mdl_access(seq[i]);
      fetch(seq[i], -1, h, w, ma, st, ok);
      n_cmp++;
      if ({ok, h, mh} !== {1'b1, exp_hit[i], exp_hit[i]}) begin
        n_bad++; $display("FAIL lru_hit_%0d: got ok/hit %b%b (model %b) want 1%b", i, ok, h, mh, exp_hit[i]);
      end
      n_cmp++;
      if (w !== mem_word(seq[i])) begin n_bad++; $display("FAIL lru_rdata_%0d: got %h want %h", i, w, mem_word(seq[i])); end
    end
    n_cmp++;
    if (miss_cnt !== 16'd4) begin n_bad++; $display("FAIL lru_miss_cnt: got %0d want 4", miss_cnt); end
  endtask

  task automatic test_flush();
    int cnt = 0;
    logic h, st, ok;
    logic [31:0] w, ma;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    while (!cpu_stall_n && cnt < 200) begin cnt++; @(negedge clk); end
    mdl_clear();
    n_cmp++;
    if (cnt != 64) begin n_bad++; $display("FAIL flush_len: got %0d stall cycles want 64", cnt); end
    void'(mdl_access(32'h44));
    fetch(32'h44, -1, h, w, ma, st, ok);
    n_cmp++;
    if ({ok, h, ma, w} !== {2'b10, 32'h40, 32'hD1}) begin
      n_bad++; $display("FAIL flush_remiss: got ok/hit %b%b addr %h data %h want 10 00000040 000000d1", ok, h, ma, w);
    end
  endtask

  task automatic test_flush_during_miss();
    int cnt = 0;
    logic h, st, ok, mh;
    logic [31:0] w, ma;
    mh = mdl_access(32'h80);
    fetch(32'h80, 1, h, w, ma, st, ok);
    n_cmp++;
    if ({ok, h, mh, w} !== {3'b100, mem_word(32'h80)}) begin
      n_bad++; $display("FAIL fdm_refill: got ok/hit %b%b data %h want 10 %h", ok, h, w, mem_word(32'h80));
    end
    @(negedge clk);
    while (!cpu_stall_n && cnt < 200) begin cnt++; @(negedge clk); end
    mdl_clear();
    n_cmp++;
    if (cnt != 64) begin n_bad++; $display("FAIL fdm_flush_len: got %0d want 64", cnt); end
    mh = mdl_access(32'h80);
    fetch(32'h80, -1, h, w, ma, st, ok);
    n_cmp++;
    if ({ok, h, mh, ma} !== {3'b100, 32'h80}) begin
      n_bad++; $display("FAIL fdm_remiss: got ok/hit %b%b addr %h want 10 00000080", ok, h, ma);
    end
  endtask

  task automatic test_flush_with_req();
    logic h, st, ok, mh;
    logic [31:0] w, ma;
    cpu_addr = 32'h80;
    cpu_req = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (cpu_stall_n !== 1'b0) begin n_bad++; $display("FAIL fwr_stall: got %b want 0", cpu_stall_n); end
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== {16'(m_hits), 16'(m_miss)}) begin
      n_bad++; $display("FAIL fwr_counts: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_miss);
    end
    mdl_clear();
    mh = mdl_access(32'h80);
    fetch(32'h80, -1, h, w, ma, st, ok);
    n_cmp++;
    if ({ok, h, w, miss_cnt} !== {1'b1, mh, mem_word(32'h80), 16'(m_miss)}) begin
      n_bad++; $display("FAIL fwr_serviced: got ok/hit %b%b data %h misses %0d want 1%b %h %0d",
                        ok, h, w, miss_cnt, mh, mem_word(32'h80), m_miss);
    end
  endtask

  task automatic test_random();
    logic h, st, ok, mh;
    logic [31:0] w, ma, a;
    int cnt;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(49) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cnt = 0;
        while (!cpu_stall_n && cnt < 200) begin cnt++; @(negedge clk); end
        mdl_clear();
      end
      a = 32'(($urandom_range(3) << 10) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2));
      mh = mdl_access(a);
      fetch(a, -1, h, w, ma, st, ok);
      n_cmp++;
      if ({ok, h, w} !== {1'b1, mh, mem_word(a)}) begin
        n_bad++; $display("FAIL rand_%0d addr %h: got ok/hit %b%b data %h want 1%b %h", k, a, ok, h, w, mh, mem_word(a));
      end
      if (!mh) begin
        n_cmp++;
        if ({st, ma} !== {1'b1, a[31:4], 4'h0}) begin
          n_bad++; $display("FAIL rand_memaddr_%0d: got stable %b addr %h want 1 %h", k, st, ma, {a[31:4], 4'h0});
        end
      end
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== {16'(m_hits), 16'(m_miss)}) begin
      n_bad++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_miss);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic h, st, ok, mh;
    logic [31:0] w, ma;
    do_reset();
    @(negedge clk);
    void'(mdl_access(32'h40));
    fetch(32'h40, -1, h, w, ma, st, ok);
    cpu_addr = 32'h2000;
    cpu_req = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmm_req_seen: got %b want 1", mem_req); end
    rst_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    m_hits = 0;
    m_miss = 0;
    n_cmp++;
    if ({mem_req, hit_cnt, miss_cnt} !== 33'h0) begin
      n_bad++; $display("FAIL rmm_after_reset: got req %b counts %0d/%0d want 0 0/0", mem_req, hit_cnt, miss_cnt);
    end
    mh = mdl_access(32'h40);
    fetch(32'h40, -1, h, w, ma, st, ok);
    n_cmp++;
    if ({ok, h, mh, ma, w} !== {3'b100, 32'h40, 32'hD0}) begin
      n_bad++; $display("FAIL rmm_remiss: got ok/hit %b%b addr %h data %h want 10 00000040 000000d0", ok, h, ma, w);
    end
  endtask

  task automatic test_saturation();
    logic h, st, ok;
    logic [31:0] w, ma;
    int misses = 0;
    int m0;
    m0 = m_miss;
    for (int k = 0; k < 65540; k++) begin
      fetch(32'h44, -1, h, w, ma, st, ok);
      if (!mdl_access(32'h44) || !h || !ok) misses++;
    end
    n_cmp++;
    if (misses != 0) begin n_bad++; $display("FAIL sat_all_hits: got %0d non-hits want 0", misses); end
    n_cmp++;
    if (hit_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hit_cnt: got %h want ffff", hit_cnt); end
    n_cmp++;
    if (miss_cnt !== 16'(m0)) begin n_bad++; $display("FAIL sat_miss_cnt: got %0d want %0d", miss_cnt, m0); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict_lru();
    test_flush();
    test_flush_during_miss();
    test_flush_with_req();
    test_random();
    test_reset_mid_miss();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i_cache_assoc.md
I_CACHE_ASSOC -- requirements
Module: i_cache_assoc

Interface
REQ-001 Parameter ADDR_W, default 32, CPU/memory address width in bits.
REQ-002 Parameter SETS, default 64, number of sets; power of two, at least 2.
REQ-003 Parameter WAYS, default 2, associativity; legal values 1 or 2.
REQ-004 Parameter LINE_WORDS, default 4, 32-bit words per line; power of two, at least 1.
REQ-005 Port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-006 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 Port cpu_req, input, 1, fetch request valid (active-high).
REQ-008 Port cpu_addr, input, ADDR_W, fetch byte address; held by CPU while stalled.
REQ-009 Port cpu_rdata, output, 32, fetched instruction word (registered).
REQ-010 Port cpu_stall_n, output, 1, 0 means stall the CPU.
REQ-011 Port mem_req, output, 1, line refill request to main memory.
REQ-012 Port mem_addr, output, ADDR_W, line-aligned refill address.
REQ-013 Port mem_ack, input, 1, memory indicates mem_rdata is valid this cycle.
REQ-014 Port mem_rdata, input, 32*LINE_WORDS, refill line; word 0 is in bits [31:0].
REQ-015 Port flush, input, 1, single-cycle pulse that invalidates the whole cache.
REQ-016 Port hit_cnt, output, 16, saturating hit counter.
REQ-017 Port miss_cnt, output, 16, saturating miss counter.

Function
REQ-018 Address split: offset = log2(LINE_WORDS)+2 LSBs; index = next log2(SETS) bits; tag = remaining MSBs.
REQ-019 Hit condition: in IDLE with cpu_req=1, any way in the indexed set is valid with a matching tag.
REQ-020 States: IDLE, MISS, REFILL, FLUSH.
REQ-021 Hit: cpu_rdata receives the addressed word at the next posedge; the set's LRU bit points to the other way; hit_cnt increments.
REQ-022 Miss in IDLE: state goes to MISS and the address is latched; miss_cnt increments.
REQ-023 MISS: mem_req=1 and mem_addr = latched address with offset bits zeroed; both held stable until mem_ack is sampled high.
REQ-024 mem_rdata is captured on the mem_ack cycle; state then goes to REFILL.
REQ-025 mem_ack is ignored while mem_req=0.
REQ-026 REFILL (one cycle): writes the line, tag and valid=1 into the victim way; cpu_rdata receives the requested word; LRU is updated; state returns to IDLE.
REQ-027 The refill delivery is not counted as a hit.
REQ-028 Victim selection: first invalid way (way 0 first); otherwise the LRU way; always way 0 when WAYS=1.
REQ-029 cpu_stall_n = 0 when state is not IDLE, or when in IDLE with cpu_req=1 and no hit (combinational).
REQ-030 cpu_stall_n = 1 otherwise.
REQ-031 flush in IDLE: state goes to FLUSH; one set's valid bits are cleared per cycle, index 0 to SETS-1, then state returns to IDLE. FLUSH lasts exactly SETS cycles.
REQ-032 flush during MISS or REFILL: a pending flag is set; FLUSH is entered on the first IDLE cycle after REFILL.
REQ-033 flush and cpu_req in the same IDLE cycle: flush wins; no counter changes; the request is serviced after FLUSH.
REQ-034 Counters saturate at 0xFFFF and never wrap.

Reset
REQ-035 On rst_n=0 at posedge: state=IDLE, all valid bits=0, all LRU bits=0, hit_cnt=0, miss_cnt=0, cpu_rdata=0, mem_req=0, mem_addr=0, pending flush=0.
REQ-036 Reset during MISS, REFILL or FLUSH abandons the operation; mem_req=0 from the next cycle.
REQ-037 Tag and data arrays are not reset.

Structure
REQ-038 Package i_cache_pkg holds: the state enumeration, the offset/index/tag width derivation functions, and the counter width constant (16).
REQ-039 Sub-module i_cache_way holds one way's tag, valid and data arrays with a clear-set port; it is instantiated WAYS times.
REQ-040 LRU bits, FSM, counters and output registers reside in i_cache_assoc.

Verification (SETS=64, WAYS=2, LINE_WORDS=4: tag[31:10], index[9:4])
REQ-041 Cold miss: after reset, read 0x40.
- Required: mem_req=1 with mem_addr=0x40.
- Stimulus: mem_ack after 3 cycles with line {0xD3,0xD2,0xD1,0xD0}.
- Required: cpu_rdata=0xD0 after REFILL; miss_cnt=1.
- Then read 0x44: hit, cpu_rdata=0xD1 next cycle, stall_n stays 1, hit_cnt=1.
REQ-042 Conflict/LRU: fill 0x040, then 0x440, then re-read 0x040, then read 0x840.
- Required: 0x840 evicts the 0x440 line.
- Then 0x040 hits and 0x440 misses; miss_cnt=4.
REQ-043 Flush: after fills, pulse flush.
- Required: cpu_stall_n=0 for exactly 64 cycles.
- Then read 0x44: miss, mem_req=1.
REQ-044 Flush during MISS: pulse flush while waiting for mem_ack.
- Required: REFILL completes and delivers the word.
- Then FLUSH runs 64 cycles.
- Then the same address misses again.
REQ-045 Reset mid-miss: assert rst_n=0 while mem_req=1.
- Required: mem_req=0 next cycle; counters=0.
- Previously filled 0x40 misses after reset.
REQ-046 Saturation: 65540 consecutive hits.
- Required: hit_cnt=0xFFFF; miss_cnt unchanged.
